// File: rtl/inst_buffer.sv
// Dual-issue instruction FIFO between fetch and the two-wide decoder.
// Optional performance counters are enabled with `define IBUF_PERF_CNT_EN.
module inst_buffer #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  pause_buffer,
    input  logic [1:0]            fetch_valid,
    input  logic [1:0][31:0]      fetch_pc,
    input  logic [1:0][31:0]      fetch_inst,
    input  logic [1:0][1:0]       fetch_is_exception,
    input  logic [1:0][1:0][6:0]  fetch_exception_cause,
    output logic                  fetch_ready,
    output logic [1:0]            dec_valid,
    output logic [1:0][31:0]      dec_pc,
    output logic [1:0][31:0]      dec_inst,
    output logic [1:0][1:0]       dec_is_exception,
    output logic [1:0][1:0][6:0]  dec_exception_cause,
    input  logic [1:0]            dec_consume,
    output logic [PTR_W:0]        count
`ifdef IBUF_PERF_CNT_EN
    ,
    output logic [31:0]           perf_full_cycles,
    output logic [31:0]           perf_empty_cycles,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam logic [PTR_W:0] LVL_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] LVL_READY = (PTR_W + 1)'(DEPTH - 2);
    localparam logic [PTR_W:0] LVL_TWO   = (PTR_W + 1)'(2);
    localparam logic [PTR_W-1:0] IDX_ONE = {{(PTR_W - 1){1'b0}}, 1'b1};

    logic [31:0]     r_pc    [DEPTH];
    logic [31:0]     r_inst  [DEPTH];
    logic [1:0]      r_exc   [DEPTH];
    logic [1:0][6:0] r_cause [DEPTH];

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [PTR_W:0]   w_count;
    logic             w_push_en;
    logic             w_wr_en0;
    logic             w_wr_en1;
    logic [1:0]       w_push_n;
    logic [1:0]       w_nvalid;
    logic [1:0]       w_pop_n;
    logic [PTR_W-1:0] w_wr_idx0;
    logic [PTR_W-1:0] w_wr_idx1;
    logic [PTR_W-1:0] w_rd_idx0;
    logic [PTR_W-1:0] w_rd_idx1;

    logic [31:0]      w_slot0_pc;
    logic [31:0]      w_slot0_inst;
    logic [1:0]       w_slot0_exc;
    logic [1:0][6:0]  w_slot0_cause;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign count       = w_count;
    assign fetch_ready = (w_count <= LVL_READY);

    // Write side: valid lanes are packed so the oldest valid lane lands at wr_ptr.
    assign w_push_en = fetch_ready & ~flush;
    assign w_wr_en0  = w_push_en & (|fetch_valid);
    assign w_wr_en1  = w_push_en & (&fetch_valid);
    assign w_push_n  = w_push_en ? {fetch_valid[0] & fetch_valid[1],
                                    fetch_valid[0] ^ fetch_valid[1]} : 2'd0;
    assign w_wr_idx0 = r_wr_ptr[PTR_W-1:0];
    assign w_wr_idx1 = w_wr_idx0 + IDX_ONE;

    assign w_slot0_pc    = fetch_valid[0] ? fetch_pc[0]              : fetch_pc[1];
    assign w_slot0_inst  = fetch_valid[0] ? fetch_inst[0]            : fetch_inst[1];
    assign w_slot0_exc   = fetch_valid[0] ? fetch_is_exception[0]    : fetch_is_exception[1];
    assign w_slot0_cause = fetch_valid[0] ? fetch_exception_cause[0] : fetch_exception_cause[1];

    always_ff @(posedge clk) begin
        if (w_wr_en0) begin
            r_pc[w_wr_idx0]    <= w_slot0_pc;
            r_inst[w_wr_idx0]  <= w_slot0_inst;
            r_exc[w_wr_idx0]   <= w_slot0_exc;
            r_cause[w_wr_idx0] <= w_slot0_cause;
        end
        if (w_wr_en1) begin
            r_pc[w_wr_idx1]    <= fetch_pc[1];
            r_inst[w_wr_idx1]  <= fetch_inst[1];
            r_exc[w_wr_idx1]   <= fetch_is_exception[1];
            r_cause[w_wr_idx1] <= fetch_exception_cause[1];
        end
    end

    // Read side
    assign w_rd_idx0 = r_rd_ptr[PTR_W-1:0];
    assign w_rd_idx1 = w_rd_idx0 + IDX_ONE;

    assign dec_valid[0] = (w_count != '0) & ~pause_buffer & ~flush;
    assign dec_valid[1] = (w_count >= LVL_TWO) & ~pause_buffer & ~flush;

    assign dec_pc[0]              = r_pc[w_rd_idx0];
    assign dec_pc[1]              = r_pc[w_rd_idx1];
    assign dec_inst[0]            = r_inst[w_rd_idx0];
    assign dec_inst[1]            = r_inst[w_rd_idx1];
    assign dec_is_exception[0]    = r_exc[w_rd_idx0];
    assign dec_is_exception[1]    = r_exc[w_rd_idx1];
    assign dec_exception_cause[0] = r_cause[w_rd_idx0];
    assign dec_exception_cause[1] = r_cause[w_rd_idx1];

    // dec_valid is thermometer coded, so its popcount is a simple remap.
    assign w_nvalid = {dec_valid[1], dec_valid[0] & ~dec_valid[1]};
    assign w_pop_n  = (dec_consume > w_nvalid) ? w_nvalid : dec_consume;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + {{(PTR_W - 1){1'b0}}, w_push_n};
            r_rd_ptr <= r_rd_ptr + {{(PTR_W - 1){1'b0}}, w_pop_n};
        end
    end

`ifdef IBUF_PERF_CNT_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_empty;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_full  <= '0;
            r_perf_empty <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((w_count == LVL_FULL) && (r_perf_full != '1)) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
            if ((w_count == '0) && !flush && (r_perf_empty != '1)) begin
                r_perf_empty <= r_perf_empty + 32'd1;
            end
            if ((|fetch_valid) && !fetch_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_full_cycles  = r_perf_full;
    assign perf_empty_cycles = r_perf_empty;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH = 16).
module tb_inst_buffer;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 pause_buffer;
    logic [1:0]           fetch_valid;
    logic [1:0][31:0]     fetch_pc;
    logic [1:0][31:0]     fetch_inst;
    logic [1:0][1:0]      fetch_is_exception;
    logic [1:0][1:0][6:0] fetch_exception_cause;
    logic                 fetch_ready;
    logic [1:0]           dec_valid;
    logic [1:0][31:0]     dec_pc;
    logic [1:0][31:0]     dec_inst;
    logic [1:0][1:0]      dec_is_exception;
    logic [1:0][1:0][6:0] dec_exception_cause;
    logic [1:0]           dec_consume;
    logic [4:0]           count;
`ifdef IBUF_PERF_CNT_EN
    logic [31:0]          perf_full_cycles;
    logic [31:0]          perf_empty_cycles;
    logic [31:0]          perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    inst_buffer #(.DEPTH(16)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .pause_buffer          (pause_buffer),
        .fetch_valid           (fetch_valid),
        .fetch_pc              (fetch_pc),
        .fetch_inst            (fetch_inst),
        .fetch_is_exception    (fetch_is_exception),
        .fetch_exception_cause (fetch_exception_cause),
        .fetch_ready           (fetch_ready),
        .dec_valid             (dec_valid),
        .dec_pc                (dec_pc),
        .dec_inst              (dec_inst),
        .dec_is_exception      (dec_is_exception),
        .dec_exception_cause   (dec_exception_cause),
        .dec_consume           (dec_consume),
        .count                 (count)
`ifdef IBUF_PERF_CNT_EN
        ,
        .perf_full_cycles      (perf_full_cycles),
        .perf_empty_cycles     (perf_empty_cycles),
        .perf_stall_cycles     (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wpc(input int i);
        return 32'h1C00_0100 + 32'(i * 4);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        flush                 = 1'b0;
        pause_buffer          = 1'b0;
        fetch_valid           = 2'b00;
        fetch_pc              = '0;
        fetch_inst            = '0;
        fetch_is_exception    = '0;
        fetch_exception_cause = '0;
        dec_consume           = 2'd0;
    endtask

    task automatic set_pair(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        fetch_valid           = v;
        fetch_pc[0]           = pc0;
        fetch_pc[1]           = pc1;
        fetch_inst[0]         = pc0 ^ 32'hA5A5_A5A5;
        fetch_inst[1]         = pc1 ^ 32'hA5A5_A5A5;
        fetch_is_exception    = '0;
        fetch_exception_cause = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (count !== 5'd0) begin
            n_errors++; $display("FAIL reset_count got %0d exp 0", count);
        end
        n_checks++;
        if (fetch_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready got %b exp 1", fetch_ready);
        end
        n_checks++;
        if (dec_valid !== 2'b00) begin
            n_errors++; $display("FAIL reset_dec_valid got %b exp 00", dec_valid);
        end
    endtask

    task automatic test_compaction;
        do_reset();
        set_pair(2'b10, 32'hDEAD_0000, 32'h1C00_0004);
        #1;
        n_checks++;
        if (dec_valid !== 2'b00) begin
            n_errors++; $display("FAIL no_bypass got %b exp 00", dec_valid);
        end
        tick();
        set_pair(2'b11, 32'h1C00_0008, 32'h1C00_000C);
        #1;
        n_checks++;
        if (dec_valid !== 2'b01 || dec_pc[0] !== 32'h1C00_0004) begin
            n_errors++;
            $display("FAIL lane1_only got v=%b pc=%h exp v=01 pc=1c000004", dec_valid, dec_pc[0]);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (dec_valid !== 2'b11) begin
            n_errors++; $display("FAIL compact_valid got %b exp 11", dec_valid);
        end
        n_checks++;
        if (dec_pc[0] !== 32'h1C00_0004 || dec_pc[1] !== 32'h1C00_0008) begin
            n_errors++;
            $display("FAIL compact_pc got %h %h exp 1c000004 1c000008", dec_pc[0], dec_pc[1]);
        end
        n_checks++;
        if (dec_inst[0] !== (32'h1C00_0004 ^ 32'hA5A5_A5A5)) begin
            n_errors++; $display("FAIL compact_inst got %h exp %h", dec_inst[0],
                                 32'h1C00_0004 ^ 32'hA5A5_A5A5);
        end
        n_checks++;
        if (count !== 5'd3) begin
            n_errors++; $display("FAIL compact_count got %0d exp 3", count);
        end
    endtask

    task automatic test_fill;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            set_pair(2'b11, 32'h2000 + 32'(k * 8), 32'h2004 + 32'(k * 8));
            tick();
        end
        idle_inputs();
        #1;
        n_checks++;
        if (count !== 5'd14 || fetch_ready !== 1'b1) begin
            n_errors++; $display("FAIL fill14 got cnt=%0d rdy=%b exp cnt=14 rdy=1", count, fetch_ready);
        end
        set_pair(2'b11, 32'h2038, 32'h203C);
        tick();
        n_checks++;
        if (count !== 5'd16 || fetch_ready !== 1'b0) begin
            n_errors++; $display("FAIL fill16 got cnt=%0d rdy=%b exp cnt=16 rdy=0", count, fetch_ready);
        end
        set_pair(2'b11, 32'h2040, 32'h2044);
        tick();
        n_checks++;
        if (count !== 5'd16) begin
            n_errors++; $display("FAIL full_ignore got %0d exp 16", count);
        end
        set_pair(2'b11, 32'h2048, 32'h204C);
        dec_consume = 2'd2;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0 || dec_valid !== 2'b11) begin
            n_errors++; $display("FAIL full_pop_ready got rdy=%b v=%b exp rdy=0 v=11",
                                 fetch_ready, dec_valid);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (count !== 5'd14 || dec_pc[0] !== 32'h2008) begin
            n_errors++; $display("FAIL full_pop got cnt=%0d pc=%h exp cnt=14 pc=2008", count, dec_pc[0]);
        end
    endtask

    task automatic check_head(input int j);
        logic [1:0]      exp_exc;
        logic [1:0][6:0] exp_cause;
        exp_exc   = (j == 7) ? 2'b01 : 2'b00;
        exp_cause = (j == 7) ? {7'h00, 7'h08} : 14'h0;
        n_checks++;
        if (dec_pc[0] !== wpc(j) || dec_inst[0] !== (wpc(j) ^ 32'hA5A5_A5A5)) begin
            n_errors++; $display("FAIL wrap_head[%0d] got pc=%h inst=%h exp pc=%h", j,
                                 dec_pc[0], dec_inst[0], wpc(j));
        end
        n_checks++;
        if (dec_is_exception[0] !== exp_exc || dec_exception_cause[0] !== exp_cause) begin
            n_errors++; $display("FAIL wrap_exc[%0d] got exc=%b cause=%h exp exc=%b cause=%h", j,
                                 dec_is_exception[0], dec_exception_cause[0], exp_exc, exp_cause);
        end
        if (dec_valid[1]) begin
            n_checks++;
            if (dec_pc[1] !== wpc(j + 1)) begin
                n_errors++; $display("FAIL wrap_slot1[%0d] got %h exp %h", j, dec_pc[1], wpc(j + 1));
            end
        end
    endtask

    task automatic test_wrap;
        int j;
        do_reset();
        j = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 7) begin
                set_pair(2'b10, 32'h0000_0BAD, wpc(i));
                fetch_is_exception[0]    = 2'b11;
                fetch_exception_cause[0] = '1;
                fetch_is_exception[1]    = 2'b01;
                fetch_exception_cause[1] = {7'h00, 7'h08};
            end else begin
                set_pair(2'b01, wpc(i), 32'h0);
            end
            dec_consume = (i >= 2) ? 2'd1 : 2'd0;
            #1;
            if (dec_valid[0] && dec_consume != 2'd0) begin
                check_head(j);
                j++;
            end
            tick();
        end
        idle_inputs();
        dec_consume = 2'd1;
        for (int k = 0; k < 40 && count != 5'd0; k++) begin
            #1;
            if (dec_valid[0]) begin
                check_head(j);
                j++;
            end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (j !== 20 || count !== 5'd0) begin
            n_errors++; $display("FAIL wrap_drain got pops=%0d cnt=%0d exp pops=20 cnt=0", j, count);
        end
    endtask

    task automatic test_pause_flush;
        do_reset();
        set_pair(2'b11, 32'h3000, 32'h3004); tick();
        set_pair(2'b11, 32'h3008, 32'h300C); tick();
        set_pair(2'b01, 32'h3010, 32'h0);    tick();
        idle_inputs();
        pause_buffer = 1'b1;
        dec_consume  = 2'd2;
        #1;
        n_checks++;
        if (dec_valid !== 2'b00) begin
            n_errors++; $display("FAIL pause_valid got %b exp 00", dec_valid);
        end
        tick();
        n_checks++;
        if (count !== 5'd5) begin
            n_errors++; $display("FAIL pause_hold got %0d exp 5", count);
        end
        set_pair(2'b11, 32'h3014, 32'h3018);
        tick();
        n_checks++;
        if (count !== 5'd7 || dec_valid !== 2'b00) begin
            n_errors++; $display("FAIL pause_push got cnt=%0d v=%b exp cnt=7 v=00", count, dec_valid);
        end
        pause_buffer = 1'b0;
        flush        = 1'b1;
        set_pair(2'b11, 32'h301C, 32'h3020);
        #1;
        n_checks++;
        if (dec_valid !== 2'b00) begin
            n_errors++; $display("FAIL flush_valid got %b exp 00", dec_valid);
        end
        pause_buffer = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (count !== 5'd0 || dec_valid !== 2'b00 || fetch_ready !== 1'b1) begin
            n_errors++; $display("FAIL flush_clear got cnt=%0d v=%b rdy=%b exp cnt=0 v=00 rdy=1",
                                 count, dec_valid, fetch_ready);
        end
    endtask

    task automatic test_over_consume;
        do_reset();
        set_pair(2'b01, 32'h4000, 32'h0);
        tick();
        idle_inputs();
        dec_consume = 2'd2;
        #1;
        n_checks++;
        if (count !== 5'd1 || dec_valid !== 2'b01) begin
            n_errors++; $display("FAIL over_pre got cnt=%0d v=%b exp cnt=1 v=01", count, dec_valid);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (count !== 5'd0 || fetch_ready !== 1'b1 || dec_valid !== 2'b00) begin
            n_errors++; $display("FAIL over_post got cnt=%0d rdy=%b v=%b exp cnt=0 rdy=1 v=00",
                                 count, fetch_ready, dec_valid);
        end
        set_pair(2'b11, 32'h4004, 32'h4008);
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (count !== 5'd2 || dec_pc[0] !== 32'h4004 || dec_pc[1] !== 32'h4008) begin
            n_errors++; $display("FAIL over_refill got cnt=%0d pc=%h %h exp cnt=2 pc=4004 4008",
                                 count, dec_pc[0], dec_pc[1]);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_pair(2'b11, 32'h5000, 32'h5004); tick();
        set_pair(2'b11, 32'h5008, 32'h500C);
        dec_consume = 2'd1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle_inputs();
        #1;
        n_checks++;
        if (count !== 5'd0 || dec_valid !== 2'b00 || fetch_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid got cnt=%0d v=%b rdy=%b exp cnt=0 v=00 rdy=1",
                                 count, dec_valid, fetch_ready);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_compaction();
        test_fill();
        test_wrap();
        test_pause_flush();
        test_over_consume();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
